// File: rtl/score_gen.sv
// -----------------------------------------------------------------------------
// score_gen
//   Running score counter and on-screen renderer for a 5-digit decimal score.
//   The score advances by one point every TICKS_PER_POINT qualifying frame
//   ticks. It is kept in BCD and saturates at 99999.
//   black_score is a zero-latency pixel mask. It is computed combinationally
//   from h_cnt/v_cnt and registered state, so it lines up with other layers.
//
//   Optional feature (macro SCORE_GEN_HI_SCORE_EN):
//     Adds a high-score register, loaded on the rising edge of game_over when
//     the current score is larger. It appears on hi_bcd and is drawn
//     24*SCALE pixels left of the score field.
// -----------------------------------------------------------------------------
module score_gen #(
    parameter logic [9:0] SCORE_X         = 10'd540,
    parameter logic [9:0] SCORE_Y         = 10'd16,
    parameter int         SCALE           = 2,
    parameter int         TICKS_PER_POINT = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        running,
    input  logic        game_over,
    input  logic        restart,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    output logic        black_score,
    output logic [19:0] score_bcd
`ifdef SCORE_GEN_HI_SCORE_EN
    ,
    output logic [19:0] hi_bcd
`endif
);

    // Geometry is evaluated in 12 bits, so the field edges and the
    // high-score offset cannot overflow.
    localparam logic [5:0]  TICK_LAST = 6'(TICKS_PER_POINT - 1);
    localparam logic [11:0] SCALE_W   = 12'(SCALE);
    localparam logic [11:0] FIELD_X   = {2'b00, SCORE_X};
    localparam logic [11:0] FIELD_Y   = {2'b00, SCORE_Y};
    localparam logic [19:0] SCORE_MAX = 20'h99999;
`ifdef SCORE_GEN_HI_SCORE_EN
    localparam logic [11:0] HI_OFF    = 12'(24 * SCALE);
`endif

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Decimal increment with a per-digit ripple carry.
    function automatic logic [19:0] bcd_inc(input logic [19:0] val);
        logic [19:0] res;
        logic        carry;
        res   = 20'h00000;
        carry = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (carry) begin
                if (val[4*i +: 4] == 4'd9) begin
                    res[4*i +: 4] = 4'd0;
                end else begin
                    res[4*i +: 4] = val[4*i +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end else begin
                res[4*i +: 4] = val[4*i +: 4];
            end
        end
        return res;
    endfunction

    // Returns 1 when a > b. The first differing digit, scanning from the
    // MSD, decides the result.
    function automatic logic bcd_gt(input logic [19:0] a, input logic [19:0] b);
        logic gt;
        logic decided;
        gt      = 1'b0;
        decided = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
                decided = 1'b1;
                gt      = (a[4*i +: 4] > b[4*i +: 4]);
            end else begin
                decided = decided;
            end
        end
        return gt;
    endfunction

    // 3x5 font. Bit 2 of each row is the leftmost cell.
    function automatic logic [2:0] glyph_row(input logic [3:0] dgt, input logic [2:0] row);
        logic [14:0] g;
        logic [2:0]  bits;
        case (dgt)
            4'd0:    g = {3'o7, 3'o5, 3'o5, 3'o5, 3'o7};
            4'd1:    g = {3'o2, 3'o6, 3'o2, 3'o2, 3'o7};
            4'd2:    g = {3'o7, 3'o1, 3'o7, 3'o4, 3'o7};
            4'd3:    g = {3'o7, 3'o1, 3'o7, 3'o1, 3'o7};
            4'd4:    g = {3'o5, 3'o5, 3'o7, 3'o1, 3'o1};
            4'd5:    g = {3'o7, 3'o4, 3'o7, 3'o1, 3'o7};
            4'd6:    g = {3'o7, 3'o4, 3'o7, 3'o5, 3'o7};
            4'd7:    g = {3'o7, 3'o1, 3'o1, 3'o1, 3'o1};
            4'd8:    g = {3'o7, 3'o5, 3'o7, 3'o5, 3'o7};
            4'd9:    g = {3'o7, 3'o5, 3'o7, 3'o1, 3'o7};
            default: g = 15'd0;
        endcase
        case (row)
            3'd0:    bits = g[14:12];
            3'd1:    bits = g[11:9];
            3'd2:    bits = g[8:6];
            3'd3:    bits = g[5:3];
            3'd4:    bits = g[2:0];
            default: bits = 3'b000;
        endcase
        return bits;
    endfunction

    // Digit idx of a 5-digit BCD value. Index 0 is the most significant digit.
    function automatic logic [3:0] pick_digit(input logic [19:0] val, input logic [2:0] idx);
        logic [3:0] d;
        case (idx)
            3'd0:    d = val[19:16];
            3'd1:    d = val[15:12];
            3'd2:    d = val[11:8];
            3'd3:    d = val[7:4];
            3'd4:    d = val[3:0];
            default: d = 4'd0;
        endcase
        return d;
    endfunction

    // Pixel lookup for a 5-digit field whose left edge sits at FIELD_X.
    // The caller pre-shifts hx to place the field elsewhere. Each digit is
    // 4 cells wide, including its trailing gap cell.
    function automatic logic field_pixel(input logic [11:0] hx,
                                         input logic [11:0] vy,
                                         input logic [19:0] val);
        logic [11:0] rel_x;
        logic [11:0] rel_y;
        logic [11:0] cell_x;
        logic [11:0] cell_y;
        logic [2:0]  bits;
        logic        pix;
        rel_x  = 12'd0;
        rel_y  = 12'd0;
        cell_x = 12'd0;
        cell_y = 12'd0;
        bits   = 3'b000;
        pix    = 1'b0;
        if ((hx >= FIELD_X) && (vy >= FIELD_Y)) begin
            rel_x  = hx - FIELD_X;
            rel_y  = vy - FIELD_Y;
            cell_x = rel_x / SCALE_W;
            cell_y = rel_y / SCALE_W;
            if ((cell_x < 12'd20) && (cell_y < 12'd5) && (cell_x[1:0] != 2'd3)) begin
                bits = glyph_row(pick_digit(val, cell_x[4:2]), cell_y[2:0]);
                case (cell_x[1:0])
                    2'd0:    pix = bits[2];
                    2'd1:    pix = bits[1];
                    2'd2:    pix = bits[0];
                    default: pix = 1'b0;
                endcase
            end else begin
                pix = 1'b0;
            end
        end else begin
            pix = 1'b0;
        end
        return pix;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [5:0]  tick_q,  tick_d;
    logic [19:0] score_q, score_d;
    logic        arm_q,   arm_d;     // blocks tick counting in the first cycle after reset release
    logic        count_s;
`ifdef SCORE_GEN_HI_SCORE_EN
    logic [19:0] hi_q,    hi_d;
    logic        go_q,    go_d;      // previous game_over, for rising-edge detection
`endif

    // Next-state logic: restart wins over ticks, and the score saturates at 99999.
    always_comb begin
        tick_d  = tick_q;
        score_d = score_q;
        arm_d   = 1'b1;
        count_s = frame_tick & running & ~game_over & arm_q;
        if (restart) begin
            tick_d  = 6'd0;
            score_d = 20'h00000;
        end else if (count_s) begin
            if (tick_q == TICK_LAST) begin
                tick_d = 6'd0;
                if (score_q != SCORE_MAX) begin
                    score_d = bcd_inc(score_q);
                end else begin
                    score_d = score_q;
                end
            end else begin
                tick_d = tick_q + 6'd1;
            end
        end else begin
            tick_d  = tick_q;
            score_d = score_q;
        end
    end

`ifdef SCORE_GEN_HI_SCORE_EN
    // High score takes the current score when a game ends with a better result.
    always_comb begin
        go_d = game_over;
        if (game_over && !go_q && bcd_gt(score_q, hi_q)) begin
            hi_d = score_q;
        end else begin
            hi_d = hi_q;
        end
    end
`endif

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q  <= 6'd0;
            score_q <= 20'h00000;
            arm_q   <= 1'b0;
`ifdef SCORE_GEN_HI_SCORE_EN
            hi_q    <= 20'h00000;
            go_q    <= 1'b0;
`endif
        end else begin
            tick_q  <= tick_d;
            score_q <= score_d;
            arm_q   <= arm_d;
`ifdef SCORE_GEN_HI_SCORE_EN
            hi_q    <= hi_d;
            go_q    <= go_d;
`endif
        end
    end

    assign score_bcd = score_q;
`ifdef SCORE_GEN_HI_SCORE_EN
    assign hi_bcd    = hi_q;
`endif

    // Pixel mask: zero latency from the beam position and registered score.
    always_comb begin
        black_score = field_pixel({2'b00, h_cnt}, {2'b00, v_cnt}, score_q);
`ifdef SCORE_GEN_HI_SCORE_EN
        black_score = black_score |
                      field_pixel({2'b00, h_cnt} + HI_OFF, {2'b00, v_cnt}, hi_q);
`endif
    end

endmodule

// File: tb/tb_score_gen.sv
// -----------------------------------------------------------------------------
// tb_score_gen
//   Randomised and directed bench for score_gen. An integer-valued model of
//   the score, tick counter and font raster supplies the expected values.
//   Honours SCORE_GEN_HI_SCORE_EN when the DUT is built with it.
// -----------------------------------------------------------------------------
module tb_score_gen;

    localparam int SX  = 540;
    localparam int SY  = 16;
    localparam int SC  = 2;
    localparam int TPP = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_tick;
    logic        running;
    logic        game_over;
    logic        restart;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        black_score;
    logic [19:0] score_bcd;
`ifdef SCORE_GEN_HI_SCORE_EN
    logic [19:0] hi_bcd;
`endif

    score_gen #(
        .SCORE_X(10'd540), .SCORE_Y(10'd16), .SCALE(SC), .TICKS_PER_POINT(TPP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .running(running),
        .game_over(game_over), .restart(restart), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .black_score(black_score), .score_bcd(score_bcd)
`ifdef SCORE_GEN_HI_SCORE_EN
        , .hi_bcd(hi_bcd)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, held as plain integers
    int m_score;
    int m_tick;
    int m_hi;
    bit m_arm;
    bit m_prev_go;

    int glyph [10][5] = '{
        '{7,5,5,5,7}, '{2,6,2,2,7}, '{7,1,7,4,7}, '{7,1,7,1,7}, '{5,5,7,1,1},
        '{7,4,7,1,7}, '{7,4,7,5,7}, '{7,1,1,1,1}, '{7,5,7,5,7}, '{7,5,7,1,7}
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int s);
        logic [19:0] r;
        int t;
        t = s;
        r = 20'h00000;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int digit_of(input int s, input int d);
        int p;
        p = 1;
        for (int i = 0; i < 4 - d; i++) p = p * 10;
        return (s / p) % 10;
    endfunction

    function automatic bit field_pix(input int h, input int v, input int x0, input int s);
        int xs;
        if (v < SY || v >= SY + 5*SC) return 1'b0;
        for (int d = 0; d < 5; d++) begin
            xs = x0 + 4*SC*d;
            if (h >= xs && h < xs + 3*SC)
                return bit'((glyph[digit_of(s, d)][(v - SY) / SC] >> (2 - (h - xs) / SC)) & 1);
        end
        return 1'b0;
    endfunction

    function automatic bit model_pix(input int h, input int v);
        bit p;
        p = field_pix(h, v, SX, m_score);
`ifdef SCORE_GEN_HI_SCORE_EN
        p = p | field_pix(h, v, SX - 24*SC, m_hi);
`endif
        return p;
    endfunction

    task automatic model_reset();
        m_score = 0; m_tick = 0; m_hi = 0; m_arm = 1'b0; m_prev_go = 1'b0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else begin
            if (game_over && !m_prev_go && m_score > m_hi) m_hi = m_score;
            m_prev_go = game_over;
            if (restart) begin
                m_score = 0;
                m_tick  = 0;
            end else if (frame_tick && running && !game_over && m_arm) begin
                if (m_tick == TPP - 1) begin
                    m_tick = 0;
                    if (m_score < 99999) m_score++;
                end else begin
                    m_tick++;
                end
            end
            m_arm = 1'b1;
        end
    endtask

    // One clock: update the model at the edge, compare registers, then probe a random pixel
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("score", 32'(score_bcd), 32'(to_bcd(m_score)));
`ifdef SCORE_GEN_HI_SCORE_EN
        check("hi", 32'(hi_bcd), 32'(to_bcd(m_hi)));
`endif
        if ($urandom_range(3, 0) != 0) begin
            h_cnt = 10'($urandom_range(SX + 20*SC + 4, SX - 24*SC - 4));
            v_cnt = 10'($urandom_range(SY + 5*SC + 3, SY - 3));
        end else begin
            h_cnt = 10'($urandom_range(1023, 0));
            v_cnt = 10'($urandom_range(1023, 0));
        end
        #1;
        check("pixel", 32'(black_score), 32'(model_pix(int'(h_cnt), int'(v_cnt))));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
        end
        frame_tick = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    task automatic pix_probe(input string tag, input int h, input int v, input bit exp);
        h_cnt = 10'(h);
        v_cnt = 10'(v);
        #1;
        check(tag, 32'(black_score), 32'(exp));
    endtask

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; running = 1'b0; game_over = 1'b0; restart = 1'b0;
        h_cnt = 10'd540; v_cnt = 10'd16;
        model_reset();

        // Reset state
        step();
        step();
        check("rst_score", 32'(score_bcd), 32'h0);
        pix_probe("rst_pix_on", 540, 16, 1'b1);
        pix_probe("rst_pix_hole", 542, 18, 1'b0);

        // Release with a tick present: that tick is not counted; then 12 ticks give 2 points
        rst_n = 1'b1; running = 1'b1; frame_tick = 1'b1;
        step();
        ticks(12);
        check("twelve_ticks", 32'(score_bcd), 32'h00002);

`ifdef SCORE_GEN_HI_SCORE_EN
        // High score follows the best finished game
        do_restart();
        ticks(123 * TPP);
        game_over = 1'b1; step();
        check("hi_123", 32'(hi_bcd), 32'h00123);
        game_over = 1'b0; step();
        do_restart();
        ticks(50 * TPP);
        game_over = 1'b1; step();
        check("hi_keeps", 32'(hi_bcd), 32'h00123);
        game_over = 1'b0; step();
`endif

        // Font/geometry points on score 00000
        do_restart();
        pix_probe("pix_corner", 540, 16, 1'b1);
        pix_probe("pix_hole", 542, 18, 1'b0);
        pix_probe("pix_gap", 546, 16, 1'b0);
        pix_probe("pix_dig1", 548, 16, 1'b1);
        pix_probe("pix_left", 539, 16, 1'b0);
        pix_probe("pix_below", 540, 26, 1'b0);

        // Restart together with a tick while tick_cnt=5
        ticks(5);
        restart = 1'b1; frame_tick = 1'b1;
        step();
        restart = 1'b0; frame_tick = 1'b0;
        check("restart_prio", 32'(score_bcd), 32'h0);
        ticks(5);
        check("tick_cleared", 32'(score_bcd), 32'h0);
        ticks(1);
        check("first_point", 32'(score_bcd), 32'h00001);

        // Decimal carry across two digits
        do_restart();
        ticks(99 * TPP);
        check("preload_99", 32'(score_bcd), 32'h00099);
        ticks(TPP);
        check("carry_100", 32'(score_bcd), 32'h00100);

        // Saturation at 99999, starting from a score preset close to the limit
        force dut.score_q = 20'h99998;
        #1;
        release dut.score_q;
        m_score = 99998;
        ticks(2 * TPP);
        check("sat_reach", 32'(score_bcd), 32'h99999);
        ticks(5 * TPP);
        check("sat_hold", 32'(score_bcd), 32'h99999);

        // Freeze while game_over is high
        do_restart();
        ticks(20);
        game_over = 1'b1;
        ticks(30);
        check("frozen", 32'(score_bcd), 32'h00003);
        game_over = 1'b0;
        running = 1'b0;
        ticks(10);
        check("not_running", 32'(score_bcd), 32'h00003);
        running = 1'b1;

        // Asynchronous reset mid-cycle, then release with a tick present
        rst_n = 1'b0;
        #1;
        check("async_rst", 32'(score_bcd), 32'h0);
        model_reset();
        step();
        rst_n = 1'b1; frame_tick = 1'b1;
        step();
        ticks(11);
        check("post_rst", 32'(score_bcd), 32'h00001);

        // Randomised play
        for (int i = 0; i < 3000; i++) begin
            running    = ($urandom_range(7, 0) != 0);
            frame_tick = $urandom_range(1, 0) == 1;
            restart    = ($urandom_range(199, 0) == 0);
            if ($urandom_range(39, 0) == 0) game_over = ~game_over;
            step();
        end
        restart = 1'b0; frame_tick = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
